// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control paths: FSM states, datapath selects,
// instruction fields and the ALU operation codes.
package mips_ctrl_pkg;

   localparam int XP_REG = 26;
   localparam int RA_REG = 31;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_IRQ      = 4'd11,
      S_EXC      = 4'd12
   } state_t;

   localparam logic [2:0] PCS_PLUS4  = 3'd0;
   localparam logic [2:0] PCS_BRANCH = 3'd1;
   localparam logic [2:0] PCS_JUMP   = 3'd2;
   localparam logic [2:0] PCS_JR     = 3'd3;
   localparam logic [2:0] PCS_IRQ    = 3'd4;
   localparam logic [2:0] PCS_EXC    = 3'd5;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;
   localparam logic [1:0] RD_XP = 2'd3;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MDR = 2'd1;
   localparam logic [1:0] M2R_PC  = 2'd2;

   localparam logic [1:0] B2_REG   = 2'd0;
   localparam logic [1:0] B2_IMM   = 2'd1;
   localparam logic [1:0] B2_FOUR  = 2'd2;
   localparam logic [1:0] B2_IMMSH = 2'd3;

   localparam logic [5:0] OP_R      = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0a;
   localparam logic [5:0] OP_SLTIU  = 6'h0b;
   localparam logic [5:0] OP_ANDI   = 6'h0c;
   localparam logic [5:0] OP_ORI    = 6'h0d;
   localparam logic [5:0] OP_LUI    = 6'h0f;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2b;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_JALR = 6'h09;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2a;
   localparam logic [5:0] F_SLTU = 6'h2b;

   localparam logic [5:0] ALU_ADD = 6'b000000;
   localparam logic [5:0] ALU_SUB = 6'b000001;
   localparam logic [5:0] ALU_AND = 6'b011000;
   localparam logic [5:0] ALU_OR  = 6'b011110;
   localparam logic [5:0] ALU_XOR = 6'b010110;
   localparam logic [5:0] ALU_NOR = 6'b010001;
   localparam logic [5:0] ALU_A   = 6'b011010;
   localparam logic [5:0] ALU_SLL = 6'b100000;
   localparam logic [5:0] ALU_SRL = 6'b100001;
   localparam logic [5:0] ALU_SRA = 6'b100011;
   localparam logic [5:0] ALU_EQ  = 6'b110011;
   localparam logic [5:0] ALU_NEQ = 6'b110001;
   localparam logic [5:0] ALU_LT  = 6'b110101;
   localparam logic [5:0] ALU_LEZ = 6'b111101;
   localparam logic [5:0] ALU_LTZ = 6'b111011;
   localparam logic [5:0] ALU_GTZ = 6'b111111;

   function automatic logic is_r_alu(input logic [5:0] f);
      return f inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                       F_SLL, F_SRL, F_SRA, F_SLT, F_SLTU};
   endfunction

   function automatic logic is_shift(input logic [5:0] f);
      return f inside {F_SLL, F_SRL, F_SRA};
   endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control-to-datapath bundle: instruction fields and status in, selects and enables out.
interface multi_cycle_control_if;
   logic       irq;
   logic       PC31;
   logic [5:0] OpCode;
   logic [5:0] Funct;
   logic       BranchTaken;
   logic       PCWrite;
   logic [2:0] PCSrc;
   logic       IorD;
   logic       IRWrite;
   logic       MemRead;
   logic       MemWrite;
   logic       RegWrite;
   logic [1:0] RegDst;
   logic [1:0] MemtoReg;
   logic       ALUSrc1;
   logic [1:0] ALUSrc2;
   logic       ExtOp;
   logic       LuOp;
   logic       Sign;
   logic [5:0] ALUFun;
   logic [3:0] State;

   modport master (
      input  irq, PC31, OpCode, Funct, BranchTaken,
      output PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, RegWrite,
             RegDst, MemtoReg, ALUSrc1, ALUSrc2, ExtOp, LuOp, Sign, ALUFun, State
   );

   modport slave (
      output irq, PC31, OpCode, Funct, BranchTaken,
      input  PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, RegWrite,
             RegDst, MemtoReg, ALUSrc1, ALUSrc2, ExtOp, LuOp, Sign, ALUFun, State
   );
endinterface

// File: rtl/control_alu_decode.sv
// Maps (OpCode, Funct) to the ALU operation and signedness; shared by both control paths.
module control_alu_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output logic [5:0] o_alufun,
   output logic       o_sign
);

   always_comb begin
      o_alufun = ALU_ADD;
      o_sign   = 1'b0;
      case (i_opcode)
         OP_R: begin
            case (i_funct)
               F_ADD:  begin o_alufun = ALU_ADD; o_sign = 1'b1; end
               F_ADDU: o_alufun = ALU_ADD;
               F_SUB:  begin o_alufun = ALU_SUB; o_sign = 1'b1; end
               F_SUBU: o_alufun = ALU_SUB;
               F_AND:  o_alufun = ALU_AND;
               F_OR:   o_alufun = ALU_OR;
               F_XOR:  o_alufun = ALU_XOR;
               F_NOR:  o_alufun = ALU_NOR;
               F_SLL:  o_alufun = ALU_SLL;
               F_SRL:  o_alufun = ALU_SRL;
               F_SRA:  o_alufun = ALU_SRA;
               F_SLT:  begin o_alufun = ALU_LT; o_sign = 1'b1; end
               F_SLTU: o_alufun = ALU_LT;
               default: o_alufun = ALU_ADD;
            endcase
         end
         OP_ADDI:   begin o_alufun = ALU_ADD; o_sign = 1'b1; end
         OP_ADDIU:  o_alufun = ALU_ADD;
         OP_SLTI:   begin o_alufun = ALU_LT; o_sign = 1'b1; end
         OP_SLTIU:  o_alufun = ALU_LT;
         OP_ANDI:   o_alufun = ALU_AND;
         OP_ORI:    o_alufun = ALU_OR;
         // lui relies on rs=$zero, so an add of the shifted immediate suffices
         OP_LUI:    o_alufun = ALU_ADD;
         OP_BEQ:    begin o_alufun = ALU_EQ;  o_sign = 1'b1; end
         OP_BNE:    begin o_alufun = ALU_NEQ; o_sign = 1'b1; end
         OP_BLEZ:   begin o_alufun = ALU_LEZ; o_sign = 1'b1; end
         OP_BGTZ:   begin o_alufun = ALU_GTZ; o_sign = 1'b1; end
         OP_REGIMM: begin o_alufun = ALU_LTZ; o_sign = 1'b1; end
         default:   o_alufun = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: state register plus Moore outputs, with
// BranchTaken and the FETCH interrupt check as the only combinational inputs.
module multi_cycle_control
   import mips_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   multi_cycle_control_if.master ctl
);

   state_t     r_state;
   state_t     w_next;
   logic [5:0] w_dec_alufun;
   logic       w_dec_sign;
   logic       w_irq_take;

   control_alu_decode u_alu_dec (
      .i_opcode (ctl.OpCode),
      .i_funct  (ctl.Funct),
      .o_alufun (w_dec_alufun),
      .o_sign   (w_dec_sign)
   );

   assign w_irq_take = ctl.irq && !ctl.PC31;
   assign ctl.State  = r_state;

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = w_irq_take ? S_IRQ : S_DECODE;
         S_DECODE: begin
            case (ctl.OpCode)
               OP_LW, OP_SW: w_next = S_MEM_ADDR;
               OP_R: begin
                  if (is_r_alu(ctl.Funct))                           w_next = S_EXEC_R;
                  else if (ctl.Funct == F_JR || ctl.Funct == F_JALR) w_next = S_JUMP;
                  else                                               w_next = S_EXC;
               end
               OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
               OP_SLTI, OP_SLTIU, OP_LUI:                  w_next = S_EXEC_I;
               OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: w_next = S_BRANCH;
               OP_J, OP_JAL:                               w_next = S_JUMP;
               default:                                    w_next = S_EXC;
            endcase
         end
         S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
         S_MEM_ADDR:         w_next = (ctl.OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:           w_next = S_MEM_WB;
         default:            w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // Reset gates every output so no partial write escapes the reset cycle.
   always_comb begin
      ctl.PCWrite  = 1'b0;
      ctl.PCSrc    = PCS_PLUS4;
      ctl.IorD     = 1'b0;
      ctl.IRWrite  = 1'b0;
      ctl.MemRead  = 1'b0;
      ctl.MemWrite = 1'b0;
      ctl.RegWrite = 1'b0;
      ctl.RegDst   = RD_RT;
      ctl.MemtoReg = M2R_ALU;
      ctl.ALUSrc1  = 1'b0;
      ctl.ALUSrc2  = B2_REG;
      ctl.ExtOp    = 1'b0;
      ctl.LuOp     = 1'b0;
      ctl.Sign     = 1'b0;
      ctl.ALUFun   = ALU_ADD;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               if (!w_irq_take) begin
                  ctl.MemRead = 1'b1;
                  ctl.IRWrite = 1'b1;
                  ctl.ALUSrc2 = B2_FOUR;
                  ctl.PCWrite = 1'b1;
               end
            end
            S_DECODE: begin
               ctl.ALUSrc2 = B2_IMMSH;
               ctl.ExtOp   = 1'b1;
            end
            S_EXEC_R: begin
               ctl.ALUSrc1 = is_shift(ctl.Funct);
               ctl.ALUFun  = w_dec_alufun;
               ctl.Sign    = w_dec_sign;
               ctl.RegDst  = RD_RD;
            end
            S_EXEC_I: begin
               ctl.ALUSrc2 = B2_IMM;
               ctl.ExtOp   = !(ctl.OpCode == OP_ANDI || ctl.OpCode == OP_ORI);
               ctl.LuOp    = (ctl.OpCode == OP_LUI);
               ctl.ALUFun  = w_dec_alufun;
               ctl.Sign    = w_dec_sign;
            end
            S_ALU_WB: begin
               ctl.RegWrite = 1'b1;
               ctl.RegDst   = (ctl.OpCode == OP_R) ? RD_RD : RD_RT;
            end
            S_MEM_ADDR: begin
               ctl.ALUSrc2 = B2_IMM;
               ctl.ExtOp   = 1'b1;
            end
            S_MEM_RD: begin
               ctl.MemRead = 1'b1;
               ctl.IorD    = 1'b1;
            end
            S_MEM_WB: begin
               ctl.RegWrite = 1'b1;
               ctl.MemtoReg = M2R_MDR;
            end
            S_MEM_WR: begin
               ctl.MemWrite = 1'b1;
               ctl.IorD     = 1'b1;
            end
            S_BRANCH: begin
               ctl.ALUFun  = w_dec_alufun;
               ctl.Sign    = w_dec_sign;
               ctl.PCSrc   = PCS_BRANCH;
               ctl.PCWrite = ctl.BranchTaken;
            end
            S_JUMP: begin
               ctl.PCWrite = 1'b1;
               if (ctl.OpCode == OP_R) begin
                  ctl.PCSrc = PCS_JR;
                  if (ctl.Funct == F_JALR) begin
                     ctl.RegWrite = 1'b1;
                     ctl.RegDst   = RD_RD;
                     ctl.MemtoReg = M2R_PC;
                  end
               end else begin
                  ctl.PCSrc = PCS_JUMP;
                  if (ctl.OpCode == OP_JAL) begin
                     ctl.RegWrite = 1'b1;
                     ctl.RegDst   = RD_RA;
                     ctl.MemtoReg = M2R_PC;
                  end
               end
            end
            S_IRQ, S_EXC: begin
               ctl.RegWrite = 1'b1;
               ctl.RegDst   = RD_XP;
               ctl.MemtoReg = M2R_PC;
               ctl.PCWrite  = 1'b1;
               ctl.PCSrc    = (r_state == S_IRQ) ? PCS_IRQ : PCS_EXC;
            end
            default: ;
         endcase
      end
   end

endmodule
